// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - single-clock FIFO with arbitrary depth, occupancy flags and error pulses
module syn_fifo #(
  parameter int DEEPTH     = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 1,
  parameter int AF_LEVEL   = DEEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int CNT_WIDTH  = $clog2(DEEPTH + 1),
  localparam int ADDR_WIDTH = $clog2(DEEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  data_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEEPTH);
  localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Explicit wrap so non-power-of-two depths never rely on binary rollover.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign data_cnt     = count;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_en & full;
      underflow <= r_en & empty;
      if (wr_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  generate
    if (DELAY == 1) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem[rd_ptr];
        end
      end
      assign rdata = rdata_q;
    end else begin : g_show_ahead
      assign rdata = empty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo.sv
// tb/tb_syn_fifo.sv - directed self-checking bench for syn_fifo
module tb_syn_fifo;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // dut_a (depth 16 defaults) and dut_b (depth 6, registered read) share stimulus.
  logic       b_w_en, b_r_en;
  logic [7:0] b_wdata;
  logic [7:0] a_rdata, b_rdata;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;

  logic       c_w_en, c_r_en;
  logic [7:0] c_wdata, c_rdata;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0] c_cnt;

  syn_fifo dut_a (
    .clk(clk), .rst(rst), .w_en(b_w_en), .wdata(b_wdata), .r_en(b_r_en),
    .rdata(a_rdata), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .data_cnt(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  syn_fifo #(.DEEPTH(6), .DATA_WIDTH(8), .DELAY(1)) dut_b (
    .clk(clk), .rst(rst), .w_en(b_w_en), .wdata(b_wdata), .r_en(b_r_en),
    .rdata(b_rdata), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .data_cnt(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  syn_fifo #(.DEEPTH(8), .DATA_WIDTH(8), .DELAY(0), .AF_LEVEL(4), .AE_LEVEL(1)) dut_c (
    .clk(clk), .rst(rst), .w_en(c_w_en), .wdata(c_wdata), .r_en(c_r_en),
    .rdata(c_rdata), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .data_cnt(c_cnt), .overflow(c_ovf), .underflow(c_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    b_w_en = 1'b0; b_r_en = 1'b0; b_wdata = 8'h00;
    c_w_en = 1'b0; c_r_en = 1'b0; c_wdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk("a_empty", 32'(a_empty), 32'd1);
      chk("a_full", 32'(a_full), 32'd0);
      chk("a_ae", 32'(a_ae), 32'd1);
      chk("a_af", 32'(a_af), 32'd0);
      chk("a_cnt", 32'(a_cnt), 32'd0);
      chk("a_rdata", 32'(a_rdata), 32'd0);
      chk("a_ovf", 32'(a_ovf), 32'd0);
      chk("a_unf", 32'(a_unf), 32'd0);
      tick();
    end

    // Fill depth-6 FIFO, then a rejected write.
    b_w_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_wdata = 8'(8'h11 + i);
      tick();
    end
    chk("b_full", 32'(b_full), 32'd1);
    chk("b_cnt_full", 32'(b_cnt), 32'd6);
    b_wdata = 8'h77;
    tick();
    chk("b_ovf_pulse", 32'(b_ovf), 32'd1);
    chk("b_cnt_ovf", 32'(b_cnt), 32'd6);
    b_w_en = 1'b0;
    tick();
    chk("b_ovf_clear", 32'(b_ovf), 32'd0);

    b_r_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_drain_rdata", 32'(b_rdata), 32'(8'h11 + i));
    end
    b_r_en = 1'b0;
    chk("b_empty_drained", 32'(b_empty), 32'd1);
    chk("b_unf_none", 32'(b_unf), 32'd0);

    // Interleaved write/read pairs across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      b_w_en = 1'b1;
      b_wdata = 8'(i);
      tick();
      b_w_en = 1'b0;
      b_r_en = 1'b1;
      tick();
      b_r_en = 1'b0;
      chk("b_wrap_rdata", 32'(b_rdata), 32'(i));
    end
    chk("b_wrap_empty", 32'(b_empty), 32'd1);

    // Simultaneous read/write at count=3.
    b_w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_wdata = 8'(8'h31 + i);
      tick();
    end
    b_r_en = 1'b1;
    b_wdata = 8'h34;
    tick();
    chk("b_rw3_cnt", 32'(b_cnt), 32'd3);
    chk("b_rw3_rdata", 32'(b_rdata), 32'h31);
    b_w_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_rw3_drain", 32'(b_rdata), 32'(8'h32 + i));
    end
    b_r_en = 1'b0;

    // Simultaneous read/write at empty.
    b_w_en = 1'b1;
    b_r_en = 1'b1;
    b_wdata = 8'h41;
    tick();
    b_w_en = 1'b0;
    b_r_en = 1'b0;
    chk("b_rw0_cnt", 32'(b_cnt), 32'd1);
    chk("b_rw0_unf", 32'(b_unf), 32'd1);
    chk("b_rw0_rdata_hold", 32'(b_rdata), 32'h34);
    tick();
    chk("b_unf_clear", 32'(b_unf), 32'd0);
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    chk("b_rw0_read", 32'(b_rdata), 32'h41);

    // Simultaneous read/write at full.
    b_w_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_wdata = 8'(8'h51 + i);
      tick();
    end
    b_r_en = 1'b1;
    b_wdata = 8'h57;
    tick();
    b_w_en = 1'b0;
    chk("b_rwf_cnt", 32'(b_cnt), 32'd5);
    chk("b_rwf_ovf", 32'(b_ovf), 32'd1);
    chk("b_rwf_rdata", 32'(b_rdata), 32'h51);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_rwf_drain", 32'(b_rdata), 32'(8'h52 + i));
    end
    b_r_en = 1'b0;
    chk("b_rwf_empty", 32'(b_empty), 32'd1);

    // Show-ahead FIFO with AF=4, AE=1.
    chk("c_rdata_rst", 32'(c_rdata), 32'd0);
    c_w_en = 1'b1;
    c_wdata = 8'hA0;
    tick();
    chk("c_empty_1", 32'(c_empty), 32'd0);
    chk("c_rdata_show", 32'(c_rdata), 32'hA0);
    chk("c_ae_1", 32'(c_ae), 32'd1);
    c_wdata = 8'hA1;
    tick();
    chk("c_ae_2", 32'(c_ae), 32'd0);
    chk("c_af_2", 32'(c_af), 32'd0);
    c_wdata = 8'hA2;
    tick();
    chk("c_af_3", 32'(c_af), 32'd0);
    c_wdata = 8'hA3;
    tick();
    c_w_en = 1'b0;
    chk("c_af_4", 32'(c_af), 32'd1);
    chk("c_cnt_4", 32'(c_cnt), 32'd4);
    c_r_en = 1'b1;
    tick();
    c_r_en = 1'b0;
    chk("c_rdata_next", 32'(c_rdata), 32'hA1);
    chk("c_af_3b", 32'(c_af), 32'd0);
    c_w_en = 1'b1;
    c_wdata = 8'hA4;
    tick();
    c_w_en = 1'b0;
    chk("c_cnt_pre_rst", 32'(c_cnt), 32'd4);

    // Reset mid-operation discards stored entries.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c_cnt_rst", 32'(c_cnt), 32'd0);
    chk("c_empty_rst", 32'(c_empty), 32'd1);
    chk("c_rdata_rst2", 32'(c_rdata), 32'd0);
    c_w_en = 1'b1;
    c_wdata = 8'hB5;
    tick();
    c_w_en = 1'b0;
    chk("c_new_show", 32'(c_rdata), 32'hB5);
    chk("c_new_cnt", 32'(c_cnt), 32'd1);
    c_r_en = 1'b1;
    tick();
    c_r_en = 1'b0;
    chk("c_new_empty", 32'(c_empty), 32'd1);
    chk("c_new_rdata0", 32'(c_rdata), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
Single-clock synchronous FIFO. It is the parametrised successor to the team's dual-clock FIFO, for buffering within one clock domain (e.g. the QSPI command/data path).
- Generalises depth to any integer ≥2, not only powers of two.
- Selectable show-ahead or registered read.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.

Parameters:
DEEPTH, 16, number of entries; any integer ≥2; pointers wrap at DEEPTH-1.
DATA_WIDTH, 8, width of wdata/rdata.
DELAY, 1, read mode: 1 = registered read (rdata valid the cycle after an accepted read); 0 = show-ahead (rdata presents the head entry while not empty).
AF_LEVEL, DEEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEEPTH.
AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEEPTH-1, and AE_LEVEL < AF_LEVEL.
(derived) CNT_WIDTH = $clog2(DEEPTH+1); ADDR_WIDTH = $clog2(DEEPTH).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
w_en  in  1  write request.
wdata  in  DATA_WIDTH  write data, sampled with w_en.
r_en  in  1  read request.
rdata  out  DATA_WIDTH  read data (timing per DELAY).
full  out  1  count == DEEPTH.
empty  out  1  count == 0.
almost_full  out  1  count ≥ AF_LEVEL.
almost_empty  out  1  count ≤ AE_LEVEL.
data_cnt  out  CNT_WIDTH  current occupancy, 0..DEEPTH.
overflow  out  1  one-cycle pulse for a rejected write.
underflow  out  1  one-cycle pulse for a rejected read.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge) values:
  - wr_ptr, rd_ptr, count, rdata, overflow, underflow = 0.
  - empty=1, full=0, almost_empty=1.
  - almost_full = 0 (since AF_LEVEL ≥ 1).
  - Memory contents are not cleared.
- Reset mid-operation discards all stored entries; the first write after reset lands at address 0.
- Write acceptance: wr_acc = w_en & ~full. On wr_acc, mem[wr_ptr] ← wdata and wr_ptr ← (wr_ptr==DEEPTH-1) ? 0 : wr_ptr+1.
- Read acceptance: rd_acc = r_en & ~empty. On rd_acc, rd_ptr advances with the same wrap rule.
- Full/empty gating: no write while full, even if a read occurs in the same cycle; no read while empty, even if a write occurs in the same cycle. There is no bypass path.
- Count: count ← count + wr_acc − rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Flags: full, empty, almost_full, almost_empty and data_cnt are decoded from the count register only. There is no combinational path from w_en/r_en to any flag.
- Write-to-read latency: a write into an empty FIFO deasserts empty on the following cycle.
- DELAY=1 (registered read):
  - On rd_acc, rdata ← mem[rd_ptr] at that edge; rdata is valid the cycle after r_en.
  - Otherwise rdata holds its value.
- DELAY=0 (show-ahead):
  - rdata = mem[rd_ptr] whenever empty=0, and 0 when empty=1.
  - An accepted read consumes the currently shown word; the next word appears after the edge.
- Error pulses:
  - overflow ← w_en & full, registered, so it is high for exactly the cycle after each rejected write.
  - underflow ← r_en & empty, same timing.
  - Rejected operations change no state.
- Non-power-of-two depth: pointer wrap uses explicit compare-and-clear, never natural binary overflow. full/empty never rely on pointer equality.

Test Plan:
- Reset then idle (DEEPTH=16): empty=1, full=0, almost_empty=1, almost_full=0, data_cnt=0, rdata=0; overflow and underflow stay 0.
- DEEPTH=6, DELAY=1: write 0x11..0x16 on 6 consecutive cycles → full=1 and data_cnt=6. A 7th write 0x77 → overflow=1 for one cycle and data_cnt stays 6. Read 6 times → rdata 0x11..0x16, each one cycle after its r_en; then empty=1.
- Wrap with DEEPTH=6: perform 20 interleaved write/read pairs with data = index → read order matches index order across three pointer wraps, with no loss or duplication.
- Simultaneous w_en=r_en=1:
  - At count=3 → count stays 3 and the oldest word is read.
  - At empty → only the write is accepted, underflow pulses, count becomes 1.
  - At full → only the read is accepted, overflow pulses, count becomes DEEPTH-1.
- DELAY=0, AF_LEVEL=4, AE_LEVEL=1:
  - Write 0xA0 → rdata=0xA0 the cycle after the write while empty=0.
  - Flag thresholds: almost_full asserts as count reaches 4; almost_empty deasserts as count reaches 2.
  - One read → rdata shows the next word.
- Reset mid-operation with count=4: assert rst for one cycle → the next cycle shows count=0 and empty=1. A subsequent write then read returns the new data, not stale entries.
